// File: rtl/sete_segmentos_multiplex_if.sv
// Bus bundle for the multiplexed 7-segment driver.
// The master side supplies display data and masks. The slave side drives the display lines.
interface sete_segmentos_multiplex_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     blank_mask;
  logic [N_DIGITS-1:0]     blink_mask;
  logic [6:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_tick;

  modport master (
    output load, value, blank_mask, blink_mask,
    input  seg, an, frame_tick
  );

  modport slave (
    input  load, value, blank_mask, blink_mask,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/sete_segmentos_multiplex.sv
// Multiplexed 7-segment display driver.
// It latches N_DIGITS hex nibbles and scans one digit per SCAN_DIV clocks.
// The first clock of every slot is blanked to prevent ghosting.
// Each digit can be blanked permanently, or made to blink at a rate counted in frames.
module sete_segmentos_multiplex #(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 250,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input logic                      clk,
  input logic                      rst,
  sete_segmentos_multiplex_if.slave bus
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] ScanLast  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  localparam logic PhaseOn  = 1'b0;
  localparam logic PhaseOff = 1'b1;

  // Output polarity: XOR with this turns logical levels into pin levels.
  localparam logic Inv = (ACTIVE_LOW != 0);

  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blink_cnt;
  logic                  phase;
  logic [4*N_DIGITS-1:0] value_r;
  logic [N_DIGITS-1:0]   blank_r;
  logic [N_DIGITS-1:0]   blink_r;

  logic [6:0]            seg_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  frame_tick_q;

  logic                  scan_wrap;
  logic                  frame_wrap;
  logic                  blink_wrap;
  logic [3:0]            nib;
  logic                  lit;
  logic [6:0]            seg_n;
  logic [N_DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    unique case (d)
      4'h0: hex7 = 7'h7E;
      4'h1: hex7 = 7'h30;
      4'h2: hex7 = 7'h6D;
      4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;
      4'h5: hex7 = 7'h5B;
      4'h6: hex7 = 7'h5F;
      4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h7B;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;
      4'hD: hex7 = 7'h3D;
      4'hE: hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == ScanLast);
  assign frame_wrap = scan_wrap && (idx == IdxLast);
  assign blink_wrap = (blink_cnt == BlinkLast);

  // Scan position and blink phase. The blink counter advances once per completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= PhaseOn;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) begin
        idx <= (idx == IdxLast) ? '0 : idx + 1'b1;
      end
      if (frame_wrap) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        if (blink_wrap) begin
          phase <= ~phase;
        end
      end
    end
  end

  // Latched display data. All digits start blanked, so the display stays dark until the first load.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
      blank_r <= '1;
      blink_r <= '0;
    end else if (bus.load) begin
      value_r <= bus.value;
      blank_r <= bus.blank_mask;
      blink_r <= bus.blink_mask;
    end
  end

  // Logical (active-high) drive for the current scan state. Slot cycle 0 is always dark.
  always_comb begin
    nib   = value_r[4*idx +: 4];
    lit   = !blank_r[idx] && !(blink_r[idx] && (phase == PhaseOff));
    seg_n = '0;
    an_n  = '0;
    if ((scan_cnt != '0) && lit) begin
      seg_n     = hex7(nib);
      an_n[idx] = 1'b1;
    end
  end

  // Output registers. Polarity is applied here, so reset drives the pins to the dark level.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= {7{Inv}};
      an_q         <= {N_DIGITS{Inv}};
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_n ^ {7{Inv}};
      an_q         <= an_n ^ {N_DIGITS{Inv}};
      frame_tick_q <= frame_wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
